// File: rtl/laser_pulse_sequencer_if.sv
// Refill bus of the laser pulse sequencer: the writer fills the inactive
// point bank and signals completion; the sequencer requests refills.
interface laser_pulse_sequencer_if #(
  parameter int ADDR_W_P = 11
);
  logic [ADDR_W_P-1:0] waddr_i;
  logic [16:0]         wdata_i;
  logic                we_i;
  logic                mem_updated_i;
  logic                update_mem_o;

  // Host / memory filler side
  modport master (
    output waddr_i, wdata_i, we_i, mem_updated_i,
    input  update_mem_o
  );

  // Sequencer side
  modport slave (
    input  waddr_i, wdata_i, we_i, mem_updated_i,
    output update_mem_o
  );
endinterface

// File: rtl/laser_pulse_sequencer.sv
// Laser pulse sequencer: after each mirror zero crossing, replays one line of
// timed points from a double-buffered point memory and fires a fixed-width
// laser pulse for every active point. Banks swap at the end of a bank when the
// filler reports the inactive bank complete.
module laser_pulse_sequencer #(
  parameter int POINTS_PER_LINE_P  = 360,
  parameter int LINES_PER_FRAME_P  = 100,
  parameter int NUMBER_OF_FRAMES_P = 5,
  parameter int PULSE_LENGTH_P     = 5,
  parameter int ADDR_W_P           = 11
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    zc_i,
  input  logic [15:0]             quarter_delay_i,
  laser_pulse_sequencer_if.slave  bus,
  output logic                    laser_trigger_o,
  output logic                    line_completed_o,
  output logic                    rd_bank_o
);

  localparam int PT_W  = (POINTS_PER_LINE_P  > 1) ? $clog2(POINTS_PER_LINE_P)  : 1;
  localparam int LN_W  = (LINES_PER_FRAME_P  > 1) ? $clog2(LINES_PER_FRAME_P)  : 1;
  localparam int FR_W  = (NUMBER_OF_FRAMES_P > 1) ? $clog2(NUMBER_OF_FRAMES_P) : 1;
  localparam int PL_W  = $clog2(PULSE_LENGTH_P + 1);
  localparam int DEPTH = 1 << ADDR_W_P;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    FETCH,
    LOAD,
    COUNT,
    LINE_END
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        delay_q, delay_d;
  logic [15:0]        tick_q, tick_d;
  logic               active_q, active_d;
  logic [PL_W-1:0]    pulse_q, pulse_d;
  logic [PT_W-1:0]    point_q, point_d;
  logic [LN_W-1:0]    line_q, line_d;
  logic [FR_W-1:0]    frame_q, frame_d;
  logic               rd_bank_q, rd_bank_d;
  logic               update_mem_q, update_mem_d;
  logic               zc_q, zc_prev_q;
  logic               zc_rise;
  logic [ADDR_W_P-1:0] raddr;
  logic [16:0]        rdata_q;

  logic [16:0] bank0_q [DEPTH];
  logic [16:0] bank1_q [DEPTH];

  assign zc_rise = zc_q & ~zc_prev_q;
  assign raddr   = ADDR_W_P'(frame_q) * ADDR_W_P'(POINTS_PER_LINE_P) + ADDR_W_P'(point_q);

  assign laser_trigger_o  = (pulse_q != '0);
  assign line_completed_o = (state_q == LINE_END);
  assign rd_bank_o        = rd_bank_q;
  assign bus.update_mem_o = update_mem_q;

  // Point memory: writes always land in the bank not being read at the time
  // the write is sampled; reads are registered. Contents survive reset.
  always_ff @(posedge clk_i) begin
    if (bus.we_i) begin
      if (rd_bank_q) begin
        bank0_q[bus.waddr_i] <= bus.wdata_i;
      end else begin
        bank1_q[bus.waddr_i] <= bus.wdata_i;
      end
    end
    rdata_q <= rd_bank_q ? bank1_q[raddr] : bank0_q[raddr];
  end

  // Sequencer state, counters, indices and zero-crossing history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      delay_q      <= '0;
      tick_q       <= '0;
      active_q     <= 1'b0;
      pulse_q      <= '0;
      point_q      <= '0;
      line_q       <= '0;
      frame_q      <= '0;
      rd_bank_q    <= 1'b0;
      update_mem_q <= 1'b1;
      zc_q         <= 1'b0;
      zc_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      tick_q       <= tick_d;
      active_q     <= active_d;
      pulse_q      <= pulse_d;
      point_q      <= point_d;
      line_q       <= line_d;
      frame_q      <= frame_d;
      rd_bank_q    <= rd_bank_d;
      update_mem_q <= update_mem_d;
      zc_q         <= zc_i;
      zc_prev_q    <= zc_q;
    end
  end

  // Next-state logic: delay after zero crossing, then fetch/load/count each
  // point; a firing active point (re)loads the pulse counter so back-to-back
  // pulses merge without a low cycle.
  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    tick_d       = tick_q;
    active_d     = active_q;
    point_d      = point_q;
    line_d       = line_q;
    frame_d      = frame_q;
    rd_bank_d    = rd_bank_q;
    update_mem_d = update_mem_q;
    pulse_d      = (pulse_q != '0) ? (pulse_q - PL_W'(1)) : pulse_q;

    case (state_q)
      IDLE: begin
        if (zc_rise) begin
          state_d = DELAY;
          delay_d = quarter_delay_i;
          point_d = '0;
        end
      end
      DELAY: begin
        if (delay_q == 16'd0) begin
          state_d = FETCH;
        end else begin
          delay_d = delay_q - 16'd1;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        tick_d   = rdata_q[15:0];
        active_d = rdata_q[16];
        state_d  = COUNT;
      end
      COUNT: begin
        if (tick_q == 16'd0) begin
          if (active_q) begin
            pulse_d = PL_W'(PULSE_LENGTH_P);
          end
          if (point_q == PT_W'(POINTS_PER_LINE_P - 1)) begin
            state_d = LINE_END;
          end else begin
            point_d = point_q + PT_W'(1);
            state_d = FETCH;
          end
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      LINE_END: begin
        state_d = IDLE;
        if (line_q == LN_W'(LINES_PER_FRAME_P - 1)) begin
          line_d = '0;
          if (frame_q == FR_W'(NUMBER_OF_FRAMES_P - 1)) begin
            frame_d = '0;
            if (bus.mem_updated_i) begin
              rd_bank_d    = ~rd_bank_q;
              update_mem_d = ~update_mem_q;
            end
          end else begin
            frame_d = frame_q + FR_W'(1);
          end
        end else begin
          line_d = line_q + LN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_laser_pulse_sequencer.sv
// Self-checking bench for laser_pulse_sequencer: a line model predicts laser
// rise/fall and line-strobe cycles, queues them at zero-crossing time, and a
// monitor pops and compares them as the DUT produces them.
module tb_laser_pulse_sequencer;

  localparam int PPL   = 4;
  localparam int LPF   = 2;
  localparam int NOF   = 2;
  localparam int PULSE = 3;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        zc = 1'b0;
  logic [15:0] quarterDelay = 16'd0;
  logic        laser;
  logic        lineC;
  logic        rdBank;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int riseQ[$];
  int fallQ[$];
  int lineQ[$];
  logic [16:0] bankMem[2][16];
  int rdBankM = 0;
  int updM = 1;
  int lineM = 0;
  int frameM = 0;
  bit monOn = 1'b0;
  logic prevLaser = 1'b0;
  logic prevLine = 1'b0;

  laser_pulse_sequencer_if #(.ADDR_W_P(AW)) bus();

  laser_pulse_sequencer #(
    .POINTS_PER_LINE_P  (PPL),
    .LINES_PER_FRAME_P  (LPF),
    .NUMBER_OF_FRAMES_P (NOF),
    .PULSE_LENGTH_P     (PULSE),
    .ADDR_W_P           (AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .zc_i             (zc),
    .quarter_delay_i  (quarterDelay),
    .bus              (bus),
    .laser_trigger_o  (laser),
    .line_completed_o (lineC),
    .rd_bank_o        (rdBank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare every laser edge and line strobe against the queued predictions.
  always @(negedge clk) begin
    if (rst || !monOn) begin
      prevLaser = laser;
      prevLine  = lineC;
    end else begin
      if (laser && !prevLaser) begin
        if (riseQ.size() == 0) checkOutput("laser unexpected rise", laser, 0);
        else checkOutput("laser rise cycle", cyc, riseQ.pop_front());
      end
      if (!laser && prevLaser) begin
        if (fallQ.size() == 0) checkOutput("laser unexpected fall", laser, 1);
        else checkOutput("laser fall cycle", cyc, fallQ.pop_front());
      end
      if (lineC && !prevLine) begin
        if (lineQ.size() == 0) checkOutput("line strobe unexpected", lineC, 0);
        else checkOutput("line strobe cycle", cyc, lineQ.pop_front());
      end
      if (lineC && prevLine) checkOutput("line strobe width", lineC, 0);
      prevLaser = laser;
      prevLine  = lineC;
    end
  end

  task automatic writeWord(input int addr, input logic [16:0] data);
    @(negedge clk);
    bus.we_i    = 1'b1;
    bus.waddr_i = AW'(addr);
    bus.wdata_i = data;
    bankMem[rdBankM ^ 1][addr] = data;
    @(negedge clk);
    bus.we_i = 1'b0;
  endtask

  function automatic void modelLineEnd();
    lineM++;
    if (lineM == LPF) begin
      lineM = 0;
      frameM++;
      if (frameM == NOF) begin
        frameM = 0;
        if (bus.mem_updated_i) begin
          rdBankM ^= 1;
          updM ^= 1;
        end
      end
    end
  endfunction

  // Drive one zero crossing and queue the predicted laser edges and strobe.
  task automatic applyStimulus(input int q, output int firstFire, output int lastFire);
    int c, f, s, e, hiStart, hiEnd;
    logic [16:0] w;
    @(negedge clk);
    c = cyc;
    quarterDelay = 16'(q);
    zc = 1'b1;
    hiStart = -1;
    hiEnd = -1;
    f = 0;
    firstFire = 0;
    for (int k = 0; k < PPL; k++) begin
      w = bankMem[rdBankM][frameM * PPL + k];
      if (k == 0) begin
        f = c + 5 + q + int'(w[15:0]);
        firstFire = f;
      end else begin
        f = f + 3 + int'(w[15:0]);
      end
      if (w[16]) begin
        s = f + 1;
        e = f + PULSE;
        if (hiStart >= 0 && s <= hiEnd + 1) begin
          hiEnd = e;
        end else begin
          if (hiStart >= 0) begin
            riseQ.push_back(hiStart);
            fallQ.push_back(hiEnd + 1);
          end
          hiStart = s;
          hiEnd = e;
        end
      end
    end
    if (hiStart >= 0) begin
      riseQ.push_back(hiStart);
      fallQ.push_back(hiEnd + 1);
    end
    lineQ.push_back(f + 1);
    lastFire = f;
    @(negedge clk);
    zc = 1'b0;
  endtask

  task automatic runLine(input int q, input bit glitch);
    int firstFire, lastFire;
    applyStimulus(q, firstFire, lastFire);
    if (glitch) begin
      while (cyc < firstFire - 1) @(negedge clk);
      zc = 1'b1;
      @(negedge clk);
      zc = 1'b0;
    end
    while (cyc < lastFire + PULSE + 3) @(negedge clk);
    modelLineEnd();
    checkOutput("laser rises drained", riseQ.size(), 0);
    checkOutput("laser falls drained", fallQ.size(), 0);
    checkOutput("line strobes drained", lineQ.size(), 0);
    checkOutput("rd_bank_o after line", rdBank, rdBankM);
    checkOutput("update_mem_o after line", bus.update_mem_o, updM);
  endtask

  // Replay a line whose contents are not modelled; only wait for its strobe.
  task automatic primeLine();
    int n;
    n = 0;
    @(negedge clk);
    zc = 1'b1;
    @(negedge clk);
    zc = 1'b0;
    while (lineC !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("prime line strobe", lineC, 1);
    repeat (3) @(negedge clk);
    modelLineEnd();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bus.we_i          = 1'b0;
    bus.waddr_i       = '0;
    bus.wdata_i       = '0;
    bus.mem_updated_i = 1'b1;

    #1 rst = 1'b1;
    #2;
    checkOutput("reset rd_bank_o", rdBank, 0);
    checkOutput("reset update_mem_o", bus.update_mem_o, 1);
    checkOutput("reset laser_trigger_o", laser, 0);
    checkOutput("reset line_completed_o", lineC, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fill bank 1 and force a swap onto it by playing out bank 0.
    for (int a = 0; a < 8; a++) writeWord(a, {1'b1, 16'd2});
    for (int l = 0; l < LPF * NOF; l++) primeLine();
    checkOutput("swap rd_bank_o", rdBank, 1);
    checkOutput("swap update_mem_o", bus.update_mem_o, 0);
    bus.mem_updated_i = 1'b0;

    // Bank 0: frame 0 with an inactive second point, frame 1 back-to-back dt=0.
    writeWord(0, {1'b1, 16'd2});
    writeWord(1, {1'b0, 16'd2});
    writeWord(2, {1'b1, 16'd2});
    writeWord(3, {1'b1, 16'd5});
    for (int a = 4; a < 8; a++) writeWord(a, {1'b1, 16'd0});

    monOn = 1'b1;
    @(negedge clk);
    runLine(10, 1'b0);
    runLine(3, 1'b1);
    runLine(0, 1'b0);
    runLine(5, 1'b0);

    bus.mem_updated_i = 1'b1;
    for (int l = 0; l < LPF * NOF; l++) runLine(int'($urandom_range(0, 20)), 1'b0);
    bus.mem_updated_i = 1'b0;
    runLine(2, 1'b0);
    runLine(0, 1'b0);
    runLine(4, 1'b0);
    runLine(1, 1'b1);

    // Reset while a pulse is high.
    monOn = 1'b0;
    @(negedge clk);
    zc = 1'b1;
    @(negedge clk);
    zc = 1'b0;
    n = 0;
    while (laser !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("laser high before reset", laser, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid-pulse reset laser_trigger_o", laser, 0);
    checkOutput("mid-pulse reset update_mem_o", bus.update_mem_o, 1);
    checkOutput("mid-pulse reset rd_bank_o", rdBank, 0);
    riseQ.delete();
    fallQ.delete();
    lineQ.delete();
    rdBankM = 0;
    updM = 1;
    lineM = 0;
    frameM = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    monOn = 1'b1;
    runLine(7, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
